// File: rtl/t03_wb_sram_responder.sv
// Wishbone B4 classic subordinate fronting a DEPTH x 32-bit byte-lane-writable SRAM array.
// Latency: ack (or err) in cycle N+1+WAIT_STATES for a request sampled at edge N; one-cycle pulse.
// Backpressure: inputs ignored while busy; dropping cyc during WAIT aborts with no ack and no write.
// Optional: define WB_ERR_EN to answer out-of-range requests with wbs_err_o instead of wbs_ack_o.
module t03_wb_sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h3300_0000,
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic [31:0] wbs_dat_o,
    output logic        busy_o
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [31:0]   dat_q;
    logic [3:0]    sel_q;
    logic          we_q;
    logic          rng_q;
    logic [31:0]   rd_q;
    logic [31:0]   mem [DEPTH];

    // Byte lanes inside a word carry no addressing meaning here.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    // Word-granular decode; subtraction wraps, so below-base addresses fail the compare.
    logic [29:0]   word_off;
    logic          in_range_in;
    logic [AW-1:0] idx_in;
    logic          req;
    assign word_off    = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign in_range_in = (wbs_adr_i >= BASE_ADDR) && (word_off[29:AW] == '0);
    assign idx_in      = word_off[AW-1:0];
    assign req         = wbs_cyc_i && wbs_stb_i;

    // With zero wait states RESP is entered straight from IDLE, before the capture registers load.
    logic [AW-1:0] rd_idx;
    logic          rd_rng;
    assign rd_idx = (state == S_IDLE) ? idx_in : idx_q;
    assign rd_rng = (state == S_IDLE) ? in_range_in : rng_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: capture, count down wait states (abortable), single response cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nx = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_nx = S_IDLE;
                end else if (cnt == 4'd0) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Request capture and wait counter; the bus is not looked at again until the transfer ends.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt   <= 4'd0;
            idx_q <= '0;
            dat_q <= 32'd0;
            sel_q <= 4'd0;
            we_q  <= 1'b0;
            rng_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q <= idx_in;
                        dat_q <= wbs_dat_i;
                        sel_q <= wbs_sel_i;
                        we_q  <= wbs_we_i;
                        rng_q <= in_range_in;
                        cnt   <= CNT_INIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: cnt <= cnt;
            endcase
        end
    end

    // Read the array on RESP entry so a write in the same transfer returns the old word.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            rd_q <= 32'd0;
        end else if (state_nx == S_RESP) begin
            rd_q <= rd_rng ? mem[rd_idx] : 32'd0;
        end else begin
            rd_q <= 32'd0;
        end
    end

    // Commit writes on the edge leaving RESP, lane by lane; reset in RESP suppresses the write.
    always_ff @(posedge CLK) begin
        if (nRST && (state == S_RESP) && we_q && rng_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
        end
    end

    // Outputs decoded from state; data forced to zero outside the ack cycle.
    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_err_o = 1'b0;
        wbs_dat_o = 32'd0;
        busy_o    = (state != S_IDLE);
        if (state == S_RESP) begin
`ifdef WB_ERR_EN
            if (rng_q) begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = rd_q;
            end else begin
                wbs_err_o = 1'b1;
            end
`else
            wbs_ack_o = 1'b1;
            wbs_dat_o = rd_q;
`endif
        end
    end

endmodule

// File: tb/tb_t03_wb_sram_responder.sv
// Bench for t03_wb_sram_responder: four instances (WAIT_STATES 1, 0, 3, 15) on a shared request bus.
// Table of directed transfers with hand-computed latency/data, plus abort, reset and stb-only sequences.
// Each instance has its own cyc/stb so only one is addressed at a time.
module tb_t03_wb_sram_responder;

    localparam logic [31:0] B = 32'h3300_0000;
    localparam logic [15:0] WS_PK = {4'd15, 4'd3, 4'd0, 4'd1};
`ifdef WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [3:0]  cyc = 4'd0;
    logic [3:0]  stb = 4'd0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0;
    logic [31:0] wdat = 32'd0;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [3:0]  busy;
    logic [31:0] rdo [4];

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        t03_wb_sram_responder #(
            .BASE_ADDR  (B),
            .DEPTH      (256),
            .WAIT_STATES(int'(WS_PK[g*4 +: 4]))
        ) u_dut (
            .CLK      (CLK),
            .nRST     (nRST),
            .wbs_cyc_i(cyc[g]),
            .wbs_stb_i(stb[g]),
            .wbs_we_i (we),
            .wbs_sel_i(sel),
            .wbs_adr_i(adr),
            .wbs_dat_i(wdat),
            .wbs_ack_o(ack[g]),
            .wbs_err_o(err[g]),
            .wbs_dat_o(rdo[g]),
            .busy_o   (busy[g])
        );
    end

    typedef struct {
        int          k;
        logic        w;
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] exp;
        int          lat;
        bit          oor;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(int k, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                                bit chk, logic [31:0] exp, int lat, bit oor);
        vec_t v;
        v.k = k; v.w = w; v.s = s; v.a = a; v.d = d;
        v.chk = chk; v.exp = exp; v.lat = lat; v.oor = oor;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge. Returns latency in cycles after the sampling edge (0 = timeout),
    // the data and ack/err seen on the response cycle, and {ack,err,busy} one cycle later.
    task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat,
                        output logic got_ack, output logic got_err, output logic [2:0] post);
        bit done;
        we = w; sel = s; adr = a; wdat = d;
        cyc[k] = 1'b1; stb[k] = 1'b1;
        lat = 0; rd = 32'd0; got_ack = 1'b0; got_err = 1'b0; done = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge CLK);
            if (ack[k] || err[k]) begin
                lat = i; rd = rdo[k]; got_ack = ack[k]; got_err = err[k]; done = 1'b1;
            end else if (i == 1) begin
                adr = a ^ 32'h0000_0010; wdat = ~d; sel = ~s; we = ~w;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        @(negedge CLK);
        post = {ack[k], err[k], busy[k]};
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic        ga;
        logic        ge;
        logic [2:0]  post;
        int          cnt;

        vt.push_back(mk(0, 1, 4'hF, B + 32'h8,   32'hDEAD_BEEF, 0, 32'h0,         2, 0));
        vt.push_back(mk(0, 0, 4'hF, B + 32'h8,   32'h0,         1, 32'hDEAD_BEEF, 2, 0));
        vt.push_back(mk(0, 1, 4'hF, B + 32'hC,   32'h1122_3344, 0, 32'h0,         2, 0));
        vt.push_back(mk(0, 1, 4'h5, B + 32'hC,   32'hAABB_CCDD, 1, 32'h1122_3344, 2, 0));
        vt.push_back(mk(0, 0, 4'h2, B + 32'hE,   32'h0,         1, 32'h11BB_33DD, 2, 0));
        vt.push_back(mk(0, 1, 4'h0, B + 32'h8,   32'hFFFF_FFFF, 1, 32'hDEAD_BEEF, 2, 0));
        vt.push_back(mk(0, 0, 4'hF, B + 32'h8,   32'h0,         1, 32'hDEAD_BEEF, 2, 0));
        vt.push_back(mk(1, 1, 4'hF, B + 32'h10,  32'hCAFE_0001, 0, 32'h0,         1, 0));
        vt.push_back(mk(1, 0, 4'hF, B + 32'h13,  32'h0,         1, 32'hCAFE_0001, 1, 0));
        vt.push_back(mk(2, 1, 4'hF, B + 32'h20,  32'h1234_5678, 0, 32'h0,         4, 0));
        vt.push_back(mk(2, 0, 4'hF, B + 32'h20,  32'h0,         1, 32'h1234_5678, 4, 0));
        vt.push_back(mk(3, 1, 4'hF, B + 32'h40,  32'h0BAD_F00D, 0, 32'h0,         16, 0));
        vt.push_back(mk(3, 0, 4'hF, B + 32'h40,  32'h0,         1, 32'h0BAD_F00D, 16, 0));
        vt.push_back(mk(0, 1, 4'hF, B,           32'h0000_1111, 0, 32'h0,         2, 0));
        vt.push_back(mk(0, 1, 4'hF, B + 32'h3FC, 32'h7777_7777, 0, 32'h0,         2, 0));
        vt.push_back(mk(0, 1, 4'hF, B + 32'h400, 32'h5555_5555, 1, 32'h0,         2, 1));
        vt.push_back(mk(0, 1, 4'hF, B - 32'h4,   32'h6666_6666, 1, 32'h0,         2, 1));
        vt.push_back(mk(0, 0, 4'hF, B + 32'h400, 32'h0,         1, 32'h0,         2, 1));
        vt.push_back(mk(0, 0, 4'hF, B - 32'h4,   32'h0,         1, 32'h0,         2, 1));
        vt.push_back(mk(0, 0, 4'hF, B,           32'h0,         1, 32'h0000_1111, 2, 0));
        vt.push_back(mk(0, 0, 4'hF, B + 32'h3FC, 32'h0,         1, 32'h7777_7777, 2, 0));

        // Reset state on every instance.
        repeat (3) @(negedge CLK);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'd0);
            chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_dat%0d", k), rdo[k], 32'd0);
        end
        nRST = 1'b1;
        @(negedge CLK);

        // Directed table.
        for (int i = 0; i < vt.size(); i++) begin
            xfer(vt[i].k, vt[i].w, vt[i].s, vt[i].a, vt[i].d, rd, lat, ga, ge, post);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("v%0d_ack", i), 32'(ga), 32'(!(vt[i].oor && ERR_EN)));
            chk($sformatf("v%0d_err", i), 32'(ge), 32'(vt[i].oor && ERR_EN));
            chk($sformatf("v%0d_dead", i), 32'(post), 32'd0);
            if (vt[i].chk) chk($sformatf("v%0d_dat", i), rd, vt[i].exp);
        end

        // stb without cyc must not start a transfer.
        stb[0] = 1'b1; cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (busy[0] || ack[0] || err[0]) cnt++;
        end
        stb[0] = 1'b0;
        chk("stb_only", 32'(cnt), 32'd0);
        @(negedge CLK);

        // Abort: WAIT_STATES=3, drop cyc after one wait cycle.
        xfer(2, 1, 4'hF, B + 32'h14, 32'h5555_AAAA, rd, lat, ga, ge, post);
        chk("abort_pre_lat", 32'(lat), 32'd4);
        we = 1'b1; sel = 4'hF; adr = B + 32'h14; wdat = 32'hFFFF_0000;
        cyc[2] = 1'b1; stb[2] = 1'b1;
        @(negedge CLK);
        chk("abort_busy_wait", 32'(busy[2]), 32'd1);
        cyc[2] = 1'b0; stb[2] = 1'b0;
        @(negedge CLK);
        chk("abort_busy_after", 32'(busy[2]), 32'd0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (ack[2] || err[2]) cnt++;
            @(negedge CLK);
        end
        chk("abort_no_ack", 32'(cnt), 32'd0);
        xfer(2, 0, 4'hF, B + 32'h14, 32'h0, rd, lat, ga, ge, post);
        chk("abort_word5", rd, 32'h5555_AAAA);

        // Reset during WAIT of a write: WAIT_STATES=15.
        xfer(3, 1, 4'hF, B + 32'h1C, 32'h7777_0007, rd, lat, ga, ge, post);
        chk("rstw_pre_lat", 32'(lat), 32'd16);
        we = 1'b1; sel = 4'hF; adr = B + 32'h1C; wdat = 32'hDEAD_0000;
        cyc[3] = 1'b1; stb[3] = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rstw_busy_wait", 32'(busy[3]), 32'd1);
        nRST = 1'b0; cyc[3] = 1'b0; stb[3] = 1'b0;
        @(negedge CLK);
        chk("rstw_outs", {29'd0, ack[3], err[3], busy[3]}, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);
        xfer(3, 0, 4'hF, B + 32'h1C, 32'h0, rd, lat, ga, ge, post);
        chk("rstw_lat", 32'(lat), 32'd16);
        chk("rstw_ack", 32'(ga), 32'd1);
        chk("rstw_word7", rd, 32'h7777_0007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/t03_wb_sram_responder.md
Name: t03_wb_sram_responder

Overview:
Wishbone B4 classic subordinate that answers the requests issued by the team's wishbone manager. It fronts a word-addressed on-chip memory array of DEPTH 32-bit words with byte-lane writes and a programmable number of wait states. It sits on the bus behind the manager, in place of or beside the SRAM wrapper. It is the responder-side model and RTL used for game-state scratch storage and for manager verification.

Parameters:
BASE_ADDR, 32'h3300_0000, byte address of word 0; must be 4-byte aligned.
DEPTH, 256, number of 32-bit words; power of two, 2..4096.
WAIT_STATES, 1, idle cycles inserted between request capture and ACK; 0..15.

Ports:
CLK  in  1  system clock, all logic on rising edge.
nRST  in  1  synchronous active-low reset.
wbs_cyc_i  in  1  bus cycle in progress.
wbs_stb_i  in  1  strobe, request valid.
wbs_we_i  in  1  1 = write, 0 = read.
wbs_sel_i  in  4  byte lane enables; bit n covers dat[8n+7:8n].
wbs_adr_i  in  32  byte address.
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  transfer-complete pulse.
wbs_err_o  out  1  error pulse; constant 0 unless WB_ERR_EN.
wbs_dat_o  out  32  read data; valid only while ack is high.
busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, CLK. Reset nRST is synchronous and active-low. nRST=0 at a rising edge forces IDLE, ack=0, err=0, dat_o=0, busy=0, wait counter=0. Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on cyc&stb at an edge, latch adr, dat, sel, we and the in-range flag. Go to WAIT, with counter loaded to WAIT_STATES-1, if WAIT_STATES>0; otherwise go to RESP.
- WAIT: counter decrements each cycle. Go to RESP when the counter reaches 0. If cyc drops, abort to IDLE with no ack and no write.
- RESP: ack (or err) high for exactly one cycle, then back to IDLE unconditionally.
- Latency: ack is high in cycle N+1+WAIT_STATES when the request was sampled at edge N. The manager deasserts stb after ack, so one dead IDLE cycle always separates transfers. A request still held in the cycle right after ack is treated as a new transfer.
- Address decode: in range iff BASE_ADDR <= adr < BASE_ADDR+4*DEPTH. Word index = (adr-BASE_ADDR)>>2. adr[1:0] is ignored.
- Writes commit at the edge that leaves RESP, and only to lanes with sel=1. sel=4'b0000 completes with ack and modifies nothing.
- Reads return the full 32-bit word regardless of sel. The memory is read at the RESP entry edge, so dat_o shows the value before a write in the same transfer.
- dat_o is 0 whenever ack=0.
- Out-of-range without WB_ERR_EN: ack as normal, read data 0, write dropped.
- Inputs are ignored while busy; a changed adr/dat mid-transfer has no effect.
- stb without cyc is ignored.
- Reset asserted in WAIT or RESP: transfer abandoned, no write, next cycle IDLE.

Optional Feature:
WB_ERR_EN
- Defined: out-of-range requests complete with a one-cycle wbs_err_o pulse in the RESP slot instead of ack, with dat_o=0 and no write. In-range behaviour is unchanged.
- Undefined: wbs_err_o tied 0 and out-of-range requests acked as described above.

Test Plan:
1. Reset, then write 32'hDEAD_BEEF to BASE_ADDR+8 with sel=4'hF, then read the same address. Required: read returns 32'hDEAD_BEEF; with WAIT_STATES=1, ack rises 2 cycles after stb is sampled.
2. Preload word 3 = 32'h1122_3344, then write 32'hAABB_CCDD to word 3 with sel=4'b0101. Required: a subsequent read returns 32'h11BB_33DD.
3. Sweep WAIT_STATES over 0, 3, 15 with back-to-back reads. Required: ack latency is 1, 4, 16 cycles, ack width is 1 cycle, and there is one dead cycle between transfers.
4. With WAIT_STATES=3, start a write to word 5 and drop cyc after 1 wait cycle. Required: no ack, busy=0 the next cycle, word 5 unchanged.
5. Access BASE_ADDR+4*DEPTH and BASE_ADDR-4. Without WB_ERR_EN: ack=1, dat_o=0, memory untouched. With WB_ERR_EN: err=1, ack=0.
6. Pull nRST low during the WAIT state of a write to word 7. Required: ack/err/busy are 0 the next cycle, word 7 unchanged, and the next transfer completes normally.
